// File: rtl/timer_dev.sv
// timer_dev: memory-mapped down-counting timer with one-shot / auto-reload
// modes and a maskable level interrupt request.
//
// Ports:
//   clk    - system clock, rising-edge active
//   reset  - asynchronous active-low reset
//   Addr   - word address [31:2] from the bridge; only Addr[3:2] decoded
//   WE     - write enable, already qualified by the bridge hit
//   Din    - write data (byte-masked by the bridge)
//   Dout   - combinational read data of the selected register
//   IRQ    - level interrupt request (pending & mask)
//
// Register map (Addr[3:2]):
//   00 CTRL   [0]=EN [2:1]=MODE (01 auto-reload, else one-shot) [3]=IM
//   01 PRESET read/write
//   10 COUNT  read-only
//   11 reserved, reads 0
module timer_dev #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam int unsigned CTRL_W = 4;
  localparam logic [1:0]  A_CTRL   = 2'b00;
  localparam logic [1:0]  A_PRESET = 2'b01;
  localparam logic [1:0]  A_COUNT  = 2'b10;
  localparam logic [1:0]  MODE_AR  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_CNT  = 2'b10,
    S_INT  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_irq_pend;

  logic               w_we_ctrl;
  logic               w_we_preset;
  logic               w_en;
  logic               w_auto;
  logic               w_pend_set;
  logic               w_pend_clr;
  logic               w_en_clr;
  logic               w_unused;

  // Register-select decode for CPU writes
  assign w_we_ctrl   = WE && (Addr[3:2] == A_CTRL);
  assign w_we_preset = WE && (Addr[3:2] == A_PRESET);

  assign w_en   = r_ctrl[0];
  assign w_auto = (r_ctrl[2:1] == MODE_AR);

  // Upper address bits and spare data bits are intentionally ignored
  assign w_unused = ^{Addr[31:4], Din};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_en) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Reload always completes, even if EN was just dropped
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!w_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > CNT_W'(1)) begin
          w_count_nxt = r_count - CNT_W'(1);
        end else begin
          // Covers COUNT==1 and COUNT==0; never wraps below zero
          w_count_nxt = '0;
          w_state_nxt = S_INT;
          w_pend_set  = 1'b1;
        end
      end
      S_INT: begin
        if (w_auto) begin
          w_state_nxt = S_LOAD;
          w_pend_clr  = 1'b1;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // CTRL: a CPU write overrides the FSM clearing EN at the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= '0;
    end else if (w_we_ctrl) begin
      r_ctrl <= Din[CTRL_W-1:0];
    end else if (w_en_clr) begin
      r_ctrl[0] <= 1'b0;
    end
  end

  // PRESET: COUNT only picks up a new value at the next LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preset <= '0;
    end else if (w_we_preset) begin
      r_preset <= Din[CNT_W-1:0];
    end
  end

  // COUNT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Interrupt pending: CPU write to CTRL/PRESET acknowledges and wins over a set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_pend <= 1'b0;
    end else if (w_we_ctrl || w_we_preset) begin
      r_irq_pend <= 1'b0;
    end else if (w_pend_set) begin
      r_irq_pend <= 1'b1;
    end else if (w_pend_clr) begin
      r_irq_pend <= 1'b0;
    end
  end

  // Read mux, no side effects
  always_comb begin
    Dout = 32'h0;
    case (Addr[3:2])
      A_CTRL:   Dout = 32'(r_ctrl);
      A_PRESET: Dout = 32'(r_preset);
      A_COUNT:  Dout = 32'(r_count);
      default:  Dout = 32'h0;
    endcase
  end

  assign IRQ = r_irq_pend & r_ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// Directed testbench for timer_dev with a scoreboard of expected values.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PRESET = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_RSV    = 2'd3;

  timer_dev #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed=%h with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'h0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'h0, a};
    WE   = 1'b0;
    #1;
    d = Dout;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] v);
    logic [31:0] d;
    expect_v(tag, v);
    rd(a, d);
    check_v(d);
  endtask

  task automatic irq_chk(input string tag, input logic v);
    expect_v(tag, {31'h0, v});
    check_v({31'h0, IRQ});
  endtask

  // Auto-reload model with PRESET=3, t = cycles after the enabling write edge
  function automatic logic [31:0] ar_cnt(input int t);
    int p;
    p = (t - 2) % 5;
    return (p < 3) ? 32'(3 - p) : 32'h0;
  endfunction

  function automatic logic ar_irq(input int t);
    return ((t - 2) % 5) == 3;
  endfunction

  initial begin
    logic [31:0] d;
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = '0;
    Din   = 32'h0;

    // Reset held: writes ignored, everything reads zero
    repeat (2) @(negedge clk);
    wr(R_CTRL, 32'h9);
    wr(R_PRESET, 32'h5);
    rd_chk("rst_ctrl", R_CTRL, 32'h0);
    rd_chk("rst_preset", R_PRESET, 32'h0);
    rd_chk("rst_count", R_COUNT, 32'h0);
    irq_chk("rst_irq", 1'b0);
    reset = 1'b1;
    @(negedge clk);
    rd_chk("rel_ctrl", R_CTRL, 32'h0);
    rd_chk("rel_preset", R_PRESET, 32'h0);
    rd_chk("rel_count", R_COUNT, 32'h0);

    // One-shot, PRESET=5
    wr(R_PRESET, 32'd5);
    wr(R_CTRL, 32'h9);
    @(negedge clk);
    @(negedge clk);
    rd_chk("os_load", R_COUNT, 32'd5);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rd_chk("os_count", R_COUNT, 32'(5 - i));
      irq_chk("os_irq_low", 1'b0);
    end
    @(negedge clk);
    rd_chk("os_zero", R_COUNT, 32'd0);
    irq_chk("os_irq_set", 1'b1);
    @(negedge clk);
    rd_chk("os_ctrl_en_clr", R_CTRL, 32'h8);
    irq_chk("os_irq_hold", 1'b1);
    repeat (3) @(negedge clk);
    irq_chk("os_irq_hold2", 1'b1);
    rd_chk("os_count_hold", R_COUNT, 32'd0);
    wr(R_PRESET, 32'd5);
    irq_chk("os_irq_ack", 1'b0);

    // Auto-reload, PRESET=3: expectations queued up front
    wr(R_PRESET, 32'd3);
    wr(R_CTRL, 32'hB);
    @(negedge clk);
    for (int t = 2; t <= 16; t++) begin
      expect_v($sformatf("ar_count_t%0d", t), ar_cnt(t));
      expect_v($sformatf("ar_irq_t%0d", t), {31'h0, ar_irq(t)});
    end
    for (int t = 2; t <= 16; t++) begin
      @(negedge clk);
      rd(R_COUNT, d);
      check_v(d);
      check_v({31'h0, IRQ});
    end
    // Mask off: counting continues, IRQ stays low
    wr(R_CTRL, 32'h3);
    for (int t = 18; t <= 27; t++) begin
      @(negedge clk);
      rd_chk($sformatf("arm_count_t%0d", t), R_COUNT, ar_cnt(t));
      irq_chk($sformatf("arm_irq_t%0d", t), 1'b0);
    end
    wr(R_CTRL, 32'h0);
    repeat (4) @(negedge clk);

    // Pause mid-count and reload
    wr(R_PRESET, 32'd10);
    wr(R_CTRL, 32'h9);
    repeat (5) @(negedge clk);
    rd_chk("pause_pre", R_COUNT, 32'd7);
    wr(R_CTRL, 32'h8);
    rd_chk("pause_edge", R_COUNT, 32'd6);
    repeat (3) @(negedge clk);
    rd_chk("pause_frozen", R_COUNT, 32'd6);
    rd_chk("pause_ctrl", R_CTRL, 32'h8);
    wr(R_PRESET, 32'd20);
    wr(R_CTRL, 32'h9);
    repeat (2) @(negedge clk);
    rd_chk("resume_load", R_COUNT, 32'd20);
    wr(R_PRESET, 32'd50);
    rd_chk("preset_wr_cnt", R_COUNT, 32'd19);
    @(negedge clk);
    rd_chk("preset_wr_cnt2", R_COUNT, 32'd18);
    rd_chk("preset_wr_val", R_PRESET, 32'd50);
    wr(R_CTRL, 32'h0);
    repeat (3) @(negedge clk);

    // PRESET=0 one-shot
    wr(R_PRESET, 32'd0);
    wr(R_CTRL, 32'h9);
    repeat (2) @(negedge clk);
    rd_chk("p0_count", R_COUNT, 32'd0);
    irq_chk("p0_irq_low", 1'b0);
    @(negedge clk);
    irq_chk("p0_irq_set", 1'b1);
    @(negedge clk);
    rd_chk("p0_ctrl", R_CTRL, 32'h8);

    // Writes to COUNT and reserved are ignored
    wr(R_COUNT, 32'h1234);
    wr(R_RSV, 32'hFFFF_FFFF);
    rd_chk("ro_count", R_COUNT, 32'd0);
    rd_chk("rsv_read", R_RSV, 32'h0);
    rd_chk("ro_preset", R_PRESET, 32'd0);
    rd_chk("ro_ctrl", R_CTRL, 32'h8);
    irq_chk("ro_irq", 1'b1);

    // Asynchronous reset mid-count
    wr(R_PRESET, 32'd10);
    wr(R_CTRL, 32'h9);
    repeat (8) @(negedge clk);
    rd_chk("ar_pre_cnt", R_COUNT, 32'd4);
    #1;
    reset = 1'b0;
    rd_chk("async_count", R_COUNT, 32'd0);
    rd_chk("async_ctrl", R_CTRL, 32'h0);
    irq_chk("async_irq", 1'b0);
    @(negedge clk);
    rd_chk("async_preset", R_PRESET, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
Memory-mapped down-counting timer: a responder on the device side of the system bridge, decoded as DEV0 (word region 0x00007F00–0x00007F0F).
- Accepts word writes and reads from the CPU through the bridge's DEV_Addr, DEV_WD and DEV0_WE signals, and returns DEV0_RD.
- Counts down from a programmed preset and raises an interrupt request toward the CPU's external-interrupt input.
- Supports one-shot and auto-reload modes.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers (max 32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when 0.
- Addr  input  30  word address [31:2] from bridge; only Addr[3:2] decoded.
- WE  input  1  write enable, already qualified by the bridge hit.
- Din  input  32  write data, byte-masked by the bridge.
- Dout  output  32  combinational read data for the selected register.
- IRQ  output  1  interrupt request, level.

Behaviour:
- Register map (Addr[3:2]):
  - 00 CTRL: bits [3:0] used, upper bits read 0. Bit0 EN. Bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00). Bit3 IM (interrupt mask, 1 = enabled).
  - 01 PRESET: read/write.
  - 10 COUNT: read-only; writes ignored.
  - 11 reserved: reads 0, writes ignored.
- Dout is a pure mux of register values; no read side effects.
- Reset (reset=0): CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state=IDLE. Consequently Dout=0 at Addr 0 and IRQ=0.
- IRQ = irq_pend & CTRL[3], combinational from registers.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET; -> CNT (even if EN dropped this cycle).
  - CNT: if EN=0 -> IDLE with COUNT frozen. Else if COUNT>1: COUNT<=COUNT-1, stay. Else if COUNT==1: COUNT<=0, ->INT, irq_pend<=1. Else (COUNT==0): ->INT, irq_pend<=1.
  - INT, MODE one-shot: CTRL.EN<=0, ->IDLE; irq_pend stays 1.
  - INT, MODE auto-reload: ->LOAD, irq_pend<=0 (one-cycle pulse).
- Latency: CTRL written with EN=1 at edge k.
  - LOAD at k+1; COUNT=PRESET at k+2.
  - For PRESET=N≥1: COUNT=0, state INT and irq_pend=1 after edge k+2+N.
  - Auto-reload period is N+2 cycles.
- irq_pend clears on any CPU write to CTRL or PRESET, in the same edge; this takes priority over being set at that edge.
- Simultaneous CPU write to CTRL and FSM clear of EN in INT: the CPU-written value wins.
- PRESET write while counting updates PRESET only. COUNT is unchanged until the next LOAD.
- Decrement never wraps: COUNT never goes below 0.
- Reset asserted mid-count: immediate return to reset values, independent of clk.

Test Plan:
- Reset: hold reset=0, toggle clk, write attempts -> all reads 0, IRQ=0; release, read CTRL/PRESET/COUNT -> 0.
- One-shot: PRESET=5, CTRL=0x9 at edge k -> COUNT=5 at k+2, 0 at k+7, IRQ=1 from k+7 and held; CTRL reads 0x8 afterward; write PRESET=5 -> IRQ=0 next edge.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ pulses 1 cycle every 5 cycles; COUNT sequence 3,2,1,0,(INT),3,…; CTRL=0x3 (IM=0) -> counting continues, IRQ stays 0.
- Pause: mid-count at COUNT=7 write CTRL=0x8 -> COUNT frozen at 6 or 7 per edge; rewrite CTRL=0x9 -> LOAD reloads PRESET.
- Edge cases: PRESET=0 one-shot -> INT two cycles after LOAD, IRQ=1; write COUNT=0x1234 and Addr[3:2]=11 -> no state change, reserved reads 0.
- Async reset at COUNT=4 mid-cycle -> outputs 0 before the next clk edge.
